// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone classic master signals for wb_cmd_master.
// Signal names match the original flat port list so that existing connections map one-to-one.
interface wb_cmd_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [AW-1:0]     cmd_adr_i;
  logic [DW-1:0]     cmd_dat_i;
  logic [DW/8-1:0]   cmd_sel_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DW-1:0]     rsp_dat_o;
  logic [1:0]        rsp_status_o;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [AW-1:0]     wb_adr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i, wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-access initiator: one bus cycle per command, response with status,
// bus-timeout watchdog and saturating err/timeout debug counters.
module wb_cmd_master #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 arst_n,
  wb_cmd_master_if.master      bus,
  output logic [7:0]           err_cnt_o,
  output logic [7:0]           tmo_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [CW-1:0]     tick;
  logic              we_q;
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     dat_q;
  logic [DW/8-1:0]   sel_q;
  logic [DW-1:0]     rsp_dat_q;
  logic [1:0]        rsp_status_q;
  logic              done;
  logic [1:0]        status_d;
  logic [DW-1:0]     rdat_d;

  // cyc/stb/valid/ready decode straight from the state register, so an async
  // reset drops them without waiting for a clock edge.
  assign bus.cmd_ready_o  = (state == IDLE);
  assign bus.wb_cyc_o     = (state == BUS);
  assign bus.wb_stb_o     = (state == BUS);
  assign bus.rsp_valid_o  = (state == RESP);
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;

  always_comb begin
    state_d  = state;
    done     = 1'b0;
    status_d = 2'b00;
    rdat_d   = '0;
    case (state)
      IDLE: if (bus.cmd_valid_i) state_d = BUS;
      BUS: begin
        // err beats ack; any real termination beats the watchdog on the same edge
        if (bus.wb_err_i) begin
          done     = 1'b1;
          status_d = 2'b01;
        end else if (bus.wb_ack_i) begin
          done     = 1'b1;
          status_d = 2'b00;
          rdat_d   = we_q ? '0 : bus.wb_dat_i;
        end else if ((TIMEOUT != 0) && (tick == TMO_LIMIT)) begin
          done     = 1'b1;
          status_d = 2'b10;
        end
        if (done) state_d = RESP;
      end
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge wb_clk_i or negedge arst_n) begin
    if (!arst_n) begin
      tick         <= '0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
      err_cnt_o    <= '0;
      tmo_cnt_o    <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid_i) begin
        we_q  <= bus.cmd_we_i;
        adr_q <= bus.cmd_adr_i;
        dat_q <= bus.cmd_dat_i;
        sel_q <= bus.cmd_sel_i;
        tick  <= '0;
      end
      if (state == BUS) begin
        if (done) begin
          rsp_dat_q    <= rdat_d;
          rsp_status_q <= status_d;
          if (status_d == 2'b01 && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 8'd1;
          if (status_d == 2'b10 && tmo_cnt_o != '1) tmo_cnt_o <= tmo_cnt_o + 8'd1;
        end else begin
          tick <= tick + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (TIMEOUT=16): waits, zero-wait read,
// err priority/saturation, watchdog, response backpressure and asynchronous reset.
module tb_wb_cmd_master;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] err_cnt, tmo_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         ncyc;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.AW(8), .DW(32)) bus ();

  wb_cmd_master #(.AW(8), .DW(32), .TIMEOUT(16)) dut (
    .wb_clk_i (clk),
    .arst_n   (arst_n),
    .bus      (bus.master),
    .err_cnt_o(err_cnt),
    .tmo_cnt_o(tmo_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one edge (DUT must be idle), leaving the DUT in BUS cycle 1.
  task automatic send_cmd(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic consume(input string tag);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check({tag, "_rsp_valid_drop"}, 64'(bus.rsp_valid_o), 64'd0);
  endtask

  initial begin
    arst_n          = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_dat_i    = '0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;

    // reset state
    #12;
    check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_tmo_cnt", 64'(tmo_cnt), 64'd0);
    #1 arst_n = 1'b1;
    tick();

    // write with 2 wait states, ack in 3rd cyc cycle
    send_cmd(1'b1, 8'h04, 32'h0000_00FF, 4'hF);
    check("wr_cyc1", 64'(bus.wb_cyc_o), 64'd1);
    check("wr_stb1", 64'(bus.wb_stb_o), 64'd1);
    check("wr_we", 64'(bus.wb_we_o), 64'd1);
    check("wr_sel", 64'(bus.wb_sel_o), 64'hF);
    check("wr_cmd_ready_busy", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    check("wr_cyc2", 64'(bus.wb_cyc_o), 64'd1);
    check("wr_adr2", 64'(bus.wb_adr_o), 64'h04);
    tick();
    check("wr_cyc3", 64'(bus.wb_cyc_o), 64'd1);
    check("wr_adr3", 64'(bus.wb_adr_o), 64'h04);
    check("wr_dat3", 64'(bus.wb_dat_o), 64'hFF);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1111_2222;
    tick();
    bus.wb_ack_i = 1'b0;
    check("wr_cyc_end", 64'(bus.wb_cyc_o), 64'd0);
    check("wr_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("wr_status", 64'(bus.rsp_status_o), 64'd0);
    check("wr_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
    consume("wr");

    // zero-wait read
    send_cmd(1'b0, 8'h00, 32'h0, 4'hF);
    check("rd_cyc1", 64'(bus.wb_cyc_o), 64'd1);
    check("rd_rsp_valid_early", 64'(bus.rsp_valid_o), 64'd0);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hA5A5_1234;
    tick();
    bus.wb_ack_i = 1'b0;
    check("rd_cyc_end", 64'(bus.wb_cyc_o), 64'd0);
    check("rd_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("rd_rsp_dat", 64'(bus.rsp_dat_o), 64'hA5A5_1234);
    check("rd_status", 64'(bus.rsp_status_o), 64'd0);
    consume("rd");

    // err and ack together: err wins
    send_cmd(1'b0, 8'h08, 32'h0, 4'hF);
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    bus.wb_dat_i = 32'hDEAD_BEEF;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    check("err_status", 64'(bus.rsp_status_o), 64'd1);
    check("err_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
    check("err_cnt1", 64'(err_cnt), 64'd1);
    consume("err");

    // err while idle is ignored
    bus.wb_err_i = 1'b1;
    tick();
    tick();
    bus.wb_err_i = 1'b0;
    check("err_idle_ignored", 64'(err_cnt), 64'd1);
    check("err_idle_no_cyc", 64'(bus.wb_cyc_o), 64'd0);

    // 299 more errors: counter saturates at 255
    for (int i = 2; i <= 300; i++) begin
      send_cmd(1'b1, 8'h0C, 32'h0, 4'h1);
      bus.wb_err_i = 1'b1;
      tick();
      bus.wb_err_i = 1'b0;
      if (i == 255) check("err_cnt255", 64'(err_cnt), 64'hFF);
      consume("err_loop");
    end
    check("err_cnt_sat", 64'(err_cnt), 64'hFF);

    // watchdog: no response, cyc high exactly 16 cycles
    send_cmd(1'b0, 8'h20, 32'h0, 4'hF);
    ncyc = 0;
    while (bus.wb_cyc_o && ncyc < 40) begin
      ncyc++;
      tick();
    end
    check("tmo_cyc_len", 64'(ncyc), 64'd16);
    check("tmo_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("tmo_status", 64'(bus.rsp_status_o), 64'd2);
    check("tmo_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
    check("tmo_cnt1", 64'(tmo_cnt), 64'd1);
    // late ack after timeout is ignored
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h7777_7777;
    tick();
    bus.wb_ack_i = 1'b0;
    check("late_ack_status", 64'(bus.rsp_status_o), 64'd2);
    check("late_ack_dat", 64'(bus.rsp_dat_o), 64'd0);
    check("late_ack_err_cnt", 64'(err_cnt), 64'hFF);
    consume("tmo");

    // ack on the watchdog-limit edge beats timeout
    send_cmd(1'b0, 8'h24, 32'h0, 4'hF);
    repeat (15) tick();
    check("lim_cyc16", 64'(bus.wb_cyc_o), 64'd1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0000_1234;
    tick();
    bus.wb_ack_i = 1'b0;
    check("lim_status", 64'(bus.rsp_status_o), 64'd0);
    check("lim_rsp_dat", 64'(bus.rsp_dat_o), 64'h1234);
    check("lim_tmo_cnt", 64'(tmo_cnt), 64'd1);
    consume("lim");

    // response backpressure with a second command waiting
    send_cmd(1'b1, 8'h08, 32'hCAFE_0001, 4'h3);
    bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i    = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 8'h10;
    bus.cmd_dat_i   = 32'h0;
    bus.cmd_sel_i   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("bp_status", 64'(bus.rsp_status_o), 64'd0);
      check("bp_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
      check("bp_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
      check("bp_no_cyc", 64'(bus.wb_cyc_o), 64'd0);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("bp_released", 64'(bus.rsp_valid_o), 64'd0);
    check("bp_idle_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("bp_not_yet", 64'(bus.wb_cyc_o), 64'd0);
    tick();
    bus.cmd_valid_i = 1'b0;
    check("bp_second_cyc", 64'(bus.wb_cyc_o), 64'd1);
    check("bp_second_adr", 64'(bus.wb_adr_o), 64'h10);
    check("bp_second_we", 64'(bus.wb_we_o), 64'd0);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0BAD_F00D;
    tick();
    bus.wb_ack_i = 1'b0;
    check("bp_second_dat", 64'(bus.rsp_dat_o), 64'h0BAD_F00D);
    consume("bp");

    // asynchronous reset while cyc is high
    send_cmd(1'b0, 8'h30, 32'h0, 4'hF);
    check("arst_pre_cyc", 64'(bus.wb_cyc_o), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    check("arst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("arst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("arst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("arst_err_cnt", 64'(err_cnt), 64'd0);
    check("arst_tmo_cnt", 64'(tmo_cnt), 64'd0);
    #4 arst_n = 1'b1;
    tick();
    send_cmd(1'b0, 8'h34, 32'h0, 4'hF);
    check("post_cyc", 64'(bus.wb_cyc_o), 64'd1);
    check("post_adr", 64'(bus.wb_adr_o), 64'h34);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h5A5A_0001;
    tick();
    bus.wb_ack_i = 1'b0;
    check("post_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("post_rsp_dat", 64'(bus.rsp_dat_o), 64'h5A5A_0001);
    check("post_status", 64'(bus.rsp_status_o), 64'd0);
    consume("post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
